// File: rtl/axi_lite_rd_arb.sv
// Two-requester AXI4-Lite read arbiter with one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to s0.
module axi_lite_rd_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  output logic                  s0_rvalid,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  input  logic                  s0_rready,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  output logic                  s1_rvalid,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  input  logic                  s1_rready,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic                  m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  output logic                  m_axi_rready,
  output logic                  gnt_id
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    win;
  logic                    in_addr, in_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Ties go to whoever was not served last; last_q resets to 1 so s0 wins first.
  always_comb begin
    win = ~s0_arvalid;
    if (s0_arvalid && s1_arvalid) win = ~last_q;
  end
`else
  always_comb begin
    win = ~s0_arvalid;
  end
`endif

  assign in_addr = (state_q == StAddr);
  assign in_data = (state_q == StData);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (s0_arvalid || s1_arvalid) begin
          state_d = StAddr;
          gnt_d   = win;
          addr_d  = win ? s1_araddr : s0_araddr;
        end
      end
      StAddr: begin
        if (m_axi_arready) state_d = StData;
      end
      StData: begin
        if (m_axi_rvalid && m_axi_rready) begin
          state_d = StIdle;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = gnt_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_axi_arvalid = in_addr;
    m_axi_araddr  = in_addr ? addr_q : '0;
    s0_arready    = in_addr & ~gnt_q & m_axi_arready;
    s1_arready    = in_addr &  gnt_q & m_axi_arready;
    m_axi_rready  = in_data & (gnt_q ? s1_rready : s0_rready);
    s0_rvalid     = 1'b0;
    s0_rdata      = '0;
    s0_rresp      = 2'b00;
    s1_rvalid     = 1'b0;
    s1_rdata      = '0;
    s1_rresp      = 2'b00;
    if (in_data && !gnt_q) begin
      s0_rvalid = m_axi_rvalid;
      s0_rdata  = m_axi_rdata;
      s0_rresp  = m_axi_rresp;
    end
    if (in_data && gnt_q) begin
      s1_rvalid = m_axi_rvalid;
      s1_rdata  = m_axi_rdata;
      s1_rresp  = m_axi_rresp;
    end
    gnt_id = gnt_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

endmodule
